// File: rtl/datapath_response_analyzer.sv
// 32-bit MISR response compactor with valid/ready intake and a programmed vector count.
// Optional on-chip golden compare (pass/fail) is built when RESP_CMP_EN is defined.
module datapath_response_analyzer #(
  parameter int unsigned        WIDTH   = 32,
  parameter logic [WIDTH-1:0]   POLY    = 32'h04C11DB7,
  parameter logic [WIDTH-1:0]   SEED    = 32'hFFFFFFFF,
  parameter int unsigned        COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vectors,
  input  logic               resp_valid,
  input  logic [WIDTH-1:0]   resp_data,
  output logic               resp_ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] vec_count
`ifdef RESP_CMP_EN
  ,
  input  logic [WIDTH-1:0]   expected_sig,
  output logic               pass,
  output logic               fail
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] tgt_q, tgt_d;
  logic               restart;
  logic [WIDTH-1:0]   misr_next;

  assign misr_next = {sig_q[WIDTH-2:0], 1'b0}
                   ^ (sig_q[WIDTH-1] ? POLY : '0)
                   ^ resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          restart = 1'b1;
          sig_d   = SEED;
          cnt_d   = '0;
          tgt_d   = num_vectors;
          state_d = (num_vectors == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // resp_ready is constant 1 in RUN, so resp_valid alone qualifies an accept
        if (resp_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + COUNT_W'(1);
          if (cnt_d == tgt_q) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_ready = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign signature  = sig_q;
  assign vec_count  = cnt_q;

`ifdef RESP_CMP_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;

  // A restart straight into DONE (num_vectors==0 from DONE) is a fresh entry too
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (restart) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end
    if ((state_d == S_DONE) && ((state_q != S_DONE) || restart)) begin
      pass_d = (sig_d == expected_sig);
      fail_d = (sig_d != expected_sig);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_datapath_response_analyzer.sv
// Self-checking bench: queue-based signature model compared every cycle, plus literal pins.
module tb_datapath_response_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_vectors = '0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        resp_ready, busy, done;
  logic [31:0] signature;
  logic [15:0] vec_count;
  logic [31:0] expected_sig = '0;
`ifdef RESP_CMP_EN
  logic        pass, fail;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_response_analyzer #(
    .WIDTH(32), .POLY(32'h04C11DB7), .SEED(32'hFFFFFFFF), .COUNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .busy(busy), .done(done), .signature(signature), .vec_count(vec_count)
`ifdef RESP_CMP_EN
    , .expected_sig(expected_sig), .pass(pass), .fail(fail)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] q [$]);
    logic [31:0] s = 32'hFFFFFFFF;
    foreach (q[i]) s = misr_step(s, q[i]);
    return s;
  endfunction

  // Model: phase 0 idle, 1 collecting, 2 finished; signature is the fold of accepted words
  int          m_phase = 0;
  logic [31:0] m_words [$];
  int          m_target = 0;
  bit          m_pass = 0, m_fail = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0; m_words.delete(); m_target = 0; m_pass = 0; m_fail = 0;
    end
    chk("resp_ready", 64'(resp_ready), 64'(m_phase == 1));
    chk("busy", 64'(busy), 64'(m_phase == 1));
    chk("done", 64'(done), 64'(m_phase == 2));
    chk("signature", 64'(signature), 64'(fold(m_words)));
    chk("vec_count", 64'(vec_count), 64'(m_words.size()));
`ifdef RESP_CMP_EN
    chk("pass", 64'(pass), 64'(m_pass));
    chk("fail", 64'(fail), 64'(m_fail));
`endif
    if (!rst) begin
      if (m_phase != 1 && start) begin
        m_words.delete();
        m_target = int'(num_vectors);
        m_pass = 0; m_fail = 0;
        m_phase = (m_target == 0) ? 2 : 1;
        if (m_phase == 2) begin
          m_pass = (fold(m_words) == expected_sig);
          m_fail = !m_pass;
        end
      end else if (m_phase == 1 && resp_valid) begin
        m_words.push_back(resp_data);
        if (m_words.size() == m_target) begin
          m_phase = 2;
          m_pass = (fold(m_words) == expected_sig);
          m_fail = !m_pass;
        end
      end
    end
  end

  task automatic pulse_start(input logic [15:0] nv);
    start = 1'b1; num_vectors = nv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int idle);
    bit acc;
    resp_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    resp_valid = 1'b1; resp_data = w;
    for (int n = 0; n < 50; n++) begin
      acc = resp_ready;
      @(posedge clk); #1;
      if (acc) begin resp_valid = 1'b0; return; end
    end
    resp_valid = 1'b0;
    chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done();
    for (int n = 0; n < 50 && !done; n++) begin @(posedge clk); #1; end
    chk("done_reached", 64'(done), 64'(1));
  endtask

  initial begin
    logic [31:0] vec4 [$];
    logic [31:0] rw [$];
    int nv;
    vec4 = '{32'h3B9ACA07, 32'h0000008F, 32'h000F4335, 32'h00020D16};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig", 64'(signature), 64'h FFFFFFFF);
    chk("rst_cnt", 64'(vec_count), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;

    // zero-length run
    @(posedge clk); #1;
    expected_sig = 32'hFFFFFFFF;
    pulse_start(16'd0);
    chk("nv0_done", 64'(done), 64'(1));
    chk("nv0_sig", 64'(signature), 64'hFFFFFFFF);
    chk("nv0_cnt", 64'(vec_count), 64'(0));

    // single zero word
    expected_sig = 32'hFB3EE249;
    pulse_start(16'd1);
    send(32'h0, 0);
    chk("one0_sig", 64'(signature), 64'hFB3EE249);
    chk("one0_cnt", 64'(vec_count), 64'(1));
    chk("one0_done", 64'(done), 64'(1));
`ifdef RESP_CMP_EN
    chk("one0_pass", 64'(pass), 64'(1));
    chk("one0_fail", 64'(fail), 64'(0));
    expected_sig = 32'h0;
    pulse_start(16'd1);
    send(32'h0, 0);
    chk("bad_pass", 64'(pass), 64'(0));
    chk("bad_fail", 64'(fail), 64'(1));
    pulse_start(16'd1);
    chk("clr_pass", 64'(pass), 64'(0));
    chk("clr_fail", 64'(fail), 64'(0));
    send(32'h0, 0);
`endif

    // single all-ones word, immediate and after idle cycles
    pulse_start(16'd1);
    send(32'hFFFFFFFF, 0);
    chk("oneF_sig", 64'(signature), 64'h04C11DB6);
    pulse_start(16'd1);
    send(32'hFFFFFFFF, 5);
    chk("oneF_idle_sig", 64'(signature), 64'h04C11DB6);

    // four-word run with a stray start mid-run, twice
    for (int r = 0; r < 2; r++) begin
      pulse_start(16'd4);
      send(vec4[0], 0);
      send(vec4[1], 1);
      pulse_start(16'd7);
      send(vec4[2], 0);
      send(vec4[3], 2);
      chk("run4_cnt", 64'(vec_count), 64'(4));
      chk("run4_done", 64'(done), 64'(1));
      chk("run4_sig", 64'(signature), 64'(fold(vec4)));
    end

    // reset mid-run, then a clean run
    pulse_start(16'd4);
    send(vec4[0], 0);
    send(vec4[1], 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_sig", 64'(signature), 64'hFFFFFFFF);
    chk("mid_rst_cnt", 64'(vec_count), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start(16'd4);
    foreach (vec4[i]) send(vec4[i], 0);
    chk("post_rst_sig", 64'(signature), 64'(fold(vec4)));

    // randomized runs
    for (int it = 0; it < 40; it++) begin
      nv = $urandom_range(0, 6);
      rw.delete();
      for (int k = 0; k < nv; k++) rw.push_back($urandom);
      expected_sig = $urandom_range(0, 1) ? fold(rw) : $urandom;
      pulse_start(16'(nv));
      foreach (rw[k]) begin
        if ($urandom_range(0, 4) == 0) pulse_start(16'($urandom_range(0, 9)));
        send(rw[k], $urandom_range(0, 3));
      end
      wait_done();
      chk("rand_sig", 64'(signature), 64'(fold(rw)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_response_analyzer.md
# datapath_response_analyzer

Response-side companion to the datapath-element stimulus benches: a 32-bit multiple-input signature register (MISR) that accepts a programmed number of output words from a unit under test (AND, OR, adder, ALU, …) over a valid/ready handshake and compacts them into one signature. It sits between a datapath element's result bus and the self-test controller, so a whole vector run can be checked with a single compare.

## Interface
- `WIDTH`, 32, response and signature width
- `POLY`, 32'h04C11DB7, feedback polynomial (taps XORed when MSB shifts out)
- `SEED`, 32'hFFFFFFFF, signature value at reset and at run start
- `COUNT_W`, 16, width of vector counters

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only)
- `num_vectors`  in  COUNT_W  number of responses to compact; sampled on accepted `start`
- `resp_valid`  in  1  `resp_data` is valid
- `resp_data`  in  WIDTH  response word from unit under test
- `resp_ready`  out  1  analyzer accepts a word this cycle
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE, held until next `start` or reset
- `signature`  out  WIDTH  current MISR contents
- `vec_count`  out  COUNT_W  responses accepted in current run
- `expected_sig`  in  WIDTH  golden signature (only with `RESP_CMP_EN`)
- `pass`, `fail`  out  1 each  compare result (only with `RESP_CMP_EN`)

## Operation
- States: IDLE, RUN, DONE (registered).
- IDLE: `resp_ready`=0. On `start`: signature←SEED, vec_count←0, target←num_vectors; go RUN, or DONE if num_vectors==0.
- RUN: `resp_ready`=1. Accept = `resp_valid && resp_ready`. On accept: signature←{signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ resp_data; vec_count←vec_count+1. If vec_count+1 == target, go DONE.
- Cycles without `resp_valid` change nothing (no shift).
- `start` in RUN is ignored.
- DONE: `resp_ready`=0, signature and vec_count frozen. `start` restarts exactly as from IDLE.
- Counters are COUNT_W bits; the maximum run is 2^COUNT_W−1 vectors, so vec_count never wraps.

## Timing
- Reset values: state IDLE, signature=SEED, vec_count=0, `resp_ready`=0, `busy`=0, `done`=0, `pass`=0, `fail`=0.
- `resp_ready`, `busy` and `done` are decoded from registered state only, with no combinational path from inputs.
- Signature and vec_count update on the edge that completes an accept and are visible the next cycle.
- `done` rises in the cycle after the final accept. With num_vectors==0, `done` rises in the cycle after `start`.
- `rst` asserted mid-run returns all state to reset values immediately. No partial signature survives.

## Configuration
- `RESP_CMP_EN` defined: `expected_sig`, `pass` and `fail` exist. On entry to DONE the block registers `pass`=(signature==expected_sig) and `fail`=!pass. Both are cleared on `start` and on reset, and are only valid while `done`=1.
- Not defined: those ports are absent, and the controller compares `signature` externally.

## Test plan
- Reset, then `start` with num_vectors=0 -> `done`=1 one cycle later, signature=FFFFFFFF, vec_count=0, `resp_ready` never high.
- num_vectors=1, resp_data=00000000 accepted -> signature=FB3EE249, vec_count=1, `done` next cycle.
- num_vectors=1, resp_data=FFFFFFFF -> signature=04C11DB6. Repeat with `resp_valid` low for 5 cycles before the word -> identical result, `busy` held throughout.
- num_vectors=4, data 3B9ACA07, 0000008F, 000F4335, 00020D16, pulse `start` again mid-run -> extra `start` ignored, vec_count=4, `done` after the 4th accept. Run twice -> identical signatures.
- Assert `rst` after 2 of 4 accepts -> signature=FFFFFFFF, vec_count=0, IDLE. A new run then matches a clean run.
- `RESP_CMP_EN`: single word 00000000 with expected_sig=FB3EE249 -> `pass`=1, `fail`=0. With expected_sig=00000000 -> `pass`=0, `fail`=1. Both clear on the next `start`.
